// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/sub with NZCV flags, one carry chunk resolved per stage
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int CW = WIDTH / STAGES;

    logic             st_v  [STAGES];
    logic [WIDTH-1:0] st_a  [STAGES];
    logic [WIDTH-1:0] st_bx [STAGES];
    logic [WIDTH-1:0] st_s  [STAGES];
    logic             st_c  [STAGES];

    logic             nxt_v  [STAGES];
    logic [WIDTH-1:0] nxt_a  [STAGES];
    logic [WIDTH-1:0] nxt_bx [STAGES];
    logic [WIDTH-1:0] nxt_s  [STAGES];
    logic             nxt_c  [STAGES];

    logic [WIDTH-1:0] bx0;
    logic             c0;
    logic [CW:0]      part;
    logic             stall;

    logic [WIDTH-1:0] fin_s;
    logic             fin_c;
    logic             fin_amsb;
    logic             fin_bmsb;

    assign bx0      = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;
    assign stall    = out_valid && !out_ready;
    assign in_ready = reset && !stall;

    assign fin_s    = st_s[STAGES-1];
    assign fin_c    = st_c[STAGES-1];
    assign fin_amsb = st_a[STAGES-1][WIDTH-1];
    assign fin_bmsb = st_bx[STAGES-1][WIDTH-1];

    // Stage i adds chunk i using the carry registered by stage i-1.
    always_comb begin
        part      = {1'b0, a[CW-1:0]} + {1'b0, bx0[CW-1:0]} + {{CW{1'b0}}, c0};
        nxt_v[0]  = in_valid;
        nxt_a[0]  = a;
        nxt_bx[0] = bx0;
        nxt_s[0]  = '0;
        nxt_s[0][CW-1:0] = part[CW-1:0];
        nxt_c[0]  = part[CW];
        for (int i = 1; i < STAGES; i++) begin
            part      = {1'b0, st_a[i-1][i*CW +: CW]} + {1'b0, st_bx[i-1][i*CW +: CW]}
                        + {{CW{1'b0}}, st_c[i-1]};
            nxt_v[i]  = st_v[i-1];
            nxt_a[i]  = st_a[i-1];
            nxt_bx[i] = st_bx[i-1];
            nxt_s[i]  = st_s[i-1];
            nxt_s[i][i*CW +: CW] = part[CW-1:0];
            nxt_c[i]  = part[CW];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                st_v[i]  <= 1'b0;
                st_a[i]  <= '0;
                st_bx[i] <= '0;
                st_s[i]  <= '0;
                st_c[i]  <= 1'b0;
            end
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= 4'b0000;
        end else if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                st_v[i]  <= nxt_v[i];
                st_a[i]  <= nxt_a[i];
                st_bx[i] <= nxt_bx[i];
                st_s[i]  <= nxt_s[i];
                st_c[i]  <= nxt_c[i];
            end
            out_valid <= st_v[STAGES-1];
            y         <= fin_s;
            flags     <= {fin_s[WIDTH-1],
                          fin_s == '0,
                          fin_c,
                          (fin_amsb == fin_bmsb) && (fin_s[WIDTH-1] != fin_amsb)};
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic [3:0]   flags;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] y;
        logic [3:0]   f;
        int           acc;
        int           stl;
        bit           seen;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] ey;
        logic [3:0]   ef;
    } vec_t;

    exp_t         q[$];
    exp_t         e_tmp;
    logic [35:0]  m_tmp;
    int           cyc = 0;
    int           stall_cnt = 0;
    logic         prev_reset = 1'b1;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_y = '0;
    logic [3:0]   prev_f = '0;
    bit           collect = 0;
    logic [W-1:0] got_y[$];
    int           got_c[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Arithmetic reference: unsigned sum for C, signed sum range for V.
    function automatic logic [35:0] model(input logic [W-1:0] a_, input logic [W-1:0] b_,
                                          input logic cin_, input logic sub_);
        logic [W-1:0] bx;
        logic [63:0]  u;
        longint       s;
        logic [W-1:0] r;
        logic         v;
        bx = sub_ ? ~b_ : b_;
        u  = {32'b0, a_} + {32'b0, bx} + {63'b0, (sub_ ? 1'b1 : cin_)};
        s  = longint'($signed(a_)) + longint'($signed(bx)) + longint'(sub_ ? 1 : int'(cin_));
        r  = u[W-1:0];
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {r, r[W-1], (r == '0), u[W], v};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!prev_reset) begin
            chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
            chk("reset_y", {32'b0, y}, 64'd0);
            chk("reset_flags", {60'b0, flags}, 64'd0);
        end
        chk("in_ready", {63'b0, in_ready}, {63'b0, reset && !(out_valid && !out_ready)});
        if (prev_stall && prev_reset) begin
            chk("hold_y", {32'b0, y}, {32'b0, prev_y});
            chk("hold_flags", {60'b0, flags}, {60'b0, prev_f});
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", {63'b0, out_valid}, 64'd0);
            end else begin
                chk("out_y", {32'b0, y}, {32'b0, q[0].y});
                chk("out_flags", {60'b0, flags}, {60'b0, q[0].f});
                if (!q[0].seen) begin
                    chk("latency", 64'(cyc - q[0].acc - 1), 64'(S + stall_cnt - q[0].stl));
                    q[0].seen = 1;
                end
                if (out_ready) begin
                    if (collect) begin
                        got_y.push_back(y);
                        got_c.push_back(cyc);
                    end
                    void'(q.pop_front());
                end
            end
        end
        if (out_valid && !out_ready) stall_cnt++;
        if (!reset) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            m_tmp      = model(a, b, cin, sub);
            e_tmp.y    = m_tmp[35:4];
            e_tmp.f    = m_tmp[3:0];
            e_tmp.acc  = cyc;
            e_tmp.stl  = stall_cnt;
            e_tmp.seen = 0;
            q.push_back(e_tmp);
        end
        prev_reset = reset;
        prev_stall = out_valid && !out_ready;
        prev_y     = y;
        prev_f     = flags;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int n;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({nm, "_lat"}, 64'(n), 64'(S + 1));
        chk({nm, "_y"}, {32'b0, y}, {32'b0, v.ey});
        chk({nm, "_flags"}, {60'b0, flags}, {60'b0, v.ef});
        tick();
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t tv[11];

    initial begin
        tv[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0110};
        tv[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011};
        tv[2]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1000};
        tv[3]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 4'b0110};
        tv[4]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 4'b1001};
        tv[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0100};
        tv[6]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1000};
        tv[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 4'b0010};
        tv[8]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 4'b0000};
        tv[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0111};
        tv[10] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 4'b0000};

        // Reset held with operands presented; they must be ignored.
        reset = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd7;
        repeat (3) tick();
        reset = 1'b1; in_valid = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 11; i++) run_vec(tv[i], $sformatf("vec%0d", i));

        // Back-to-back stream, results must land on consecutive cycles.
        collect = 1;
        for (int i = 0; i < 8; i++) begin
            a = i; b = 32'h10 * i; cin = i[0]; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (10) tick();
        collect = 0;
        chk("stream_count", 64'(got_y.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_y.size(); i++) begin
            chk($sformatf("stream_y%0d", i), {32'b0, got_y[i]}, 64'(i + 16 * i + (i & 1)));
            chk($sformatf("stream_cyc%0d", i), 64'(got_c[i] - got_c[0]), 64'(i));
        end

        // Backpressure with the pipe full.
        for (int i = 0; i < 6; i++) begin
            a = rnd(); b = rnd(); cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (10) tick();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + i; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (8) tick();
        run_vec('{32'h0000_0020, 32'h0000_0022, 1'b1, 1'b0, 32'h0000_0043, 4'b0000}, "post_reset");

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 400; i++) begin
            a = rnd(); b = rnd(); cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) != 0);
            tick();
        end

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined integer adder/subtractor with a valid/ready handshake and ARM-style NZCV flag generation. The carry chain is split into `STAGES` equal chunks, with one chunk resolved per pipeline stage. This gives one operation per cycle at a shorter critical path than a flat `WIDTH`-bit add. It is used wherever the datapath needs a registered, multi-cycle adder, such as the PC/branch-target path or ALU experiments.

## Interface
- `WIDTH`, 32, operand and result width; must satisfy `WIDTH % STAGES == 0`.
- `STAGES`, 4, number of pipeline stages (≥1). Chunk width is `CW = WIDTH/STAGES`.

- `clk` input 1, the only clock; everything is sampled on the rising edge.
- `reset` input 1, synchronous, active-low (0 = reset).
- `a` input `WIDTH`, operand A.
- `b` input `WIDTH`, operand B.
- `cin` input 1, carry-in for add mode; ignored when `sub`=1.
- `sub` input 1, mode select: 0 computes `a+b+cin`, 1 computes `a+~b+1` (that is, `a-b`).
- `in_valid` input 1, the operand set is valid.
- `in_ready` output 1, the block accepts operands this cycle.
- `out_valid` output 1, the result is valid.
- `out_ready` input 1, the consumer accepts the result.
- `y` output `WIDTH`, sum/difference modulo 2^WIDTH.
- `flags` output 4, `{N,Z,C,V}`.

## Operation
- An operation is accepted on a rising edge where `reset`=1, `in_valid`=1 and `in_ready`=1.
- Operand preparation at stage 0:
  - `bx = sub ? ~b : b`
  - `c0 = sub ? 1 : cin`
- Stage i (0..STAGES-1) adds chunk i of `a` and `bx` plus the carry from stage i-1 (or `c0` for stage 0).
  - It registers the CW-bit partial sum and the carry out.
  - Unprocessed upper chunks of `a`/`bx` and completed lower sum chunks travel alongside in pipeline registers.
- Each stage holds a valid bit; a bubble (valid=0) propagates like data.
- Flags are computed from the final stage outputs, registered with `y`:
  - N = `y[WIDTH-1]`
  - Z = (`y`==0)
  - C = carry out of bit WIDTH-1. In sub mode C=1 means no borrow (ARM convention).
  - V = (`a[MSB]`==`bx[MSB]`) && (`y[MSB]`!=`a[MSB]`). `a[MSB]` and `bx[MSB]` are carried down the pipe.
- Stall rule is global:
  - `stall = out_valid && !out_ready`.
  - While stalled, every stage register holds, including bubbles.
  - `in_ready = reset && !stall`. This is combinational.
- Ordering: results emerge strictly in acceptance order. There is no drop and no duplication.
- `STAGES`=1 degenerates to a single registered full-width adder with handshake.

## Timing
- Reset (`reset`=0 at a rising edge):
  - All stage valid bits clear; `out_valid`=0, `y`=0, `flags`=4'b0000. The data registers also clear.
  - `in_ready`=0 while `reset`=0, and `in_valid` is ignored.
  - In-flight operations are discarded and never emitted.
- Latency: an operation accepted at edge k drives `out_valid`=1 with its result after edge k+STAGES, provided no stall cycles intervene. Each stall cycle adds one cycle.
- Throughput: 1 operation/cycle while `out_ready`=1.
- Output handshake: a result is consumed on an edge with `out_valid`=1 and `out_ready`=1.
  - While `out_valid`=1 and `out_ready`=0, `y`/`flags` hold stable.
  - The upstream pipeline also freezes.
- Simultaneous consume and accept on the same edge (pipeline full, `out_ready`=1, `in_valid`=1) is legal. The pipe advances by one.
- `in_valid` may drop at any cycle; bubbles are inserted and `out_valid`=0 for the corresponding output cycle.
- Wrap-around: results are modulo 2^WIDTH; overflow is reported only via C/V.

## Test plan
1. Reset: hold `reset`=0 for 3 cycles with `in_valid`=1, a=5, b=7.
   -> `out_valid`=0, `y`=0, `flags`=0 and `in_ready`=0 throughout; after release, `in_ready`=1 and nothing is emitted for the ignored inputs.
2. Full carry ripple (WIDTH=32, STAGES=4): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0.
   -> after 4 cycles, `y`=0x00000000, flags N=0, Z=1, C=1, V=0.
3. Subtract overflow: a=0x80000000, b=0x00000001, sub=1.
   -> `y`=0x7FFFFFFF, N=0, Z=0, C=1, V=1. Also a=3, b=5, sub=1 -> `y`=0xFFFFFFFE, N=1, C=0, V=0.
4. Streaming: 8 back-to-back operations (a=i, b=0x10*i, cin=i&1) with `out_ready`=1.
   -> results `i+0x10*i+(i&1)` appear on 8 consecutive cycles starting 4 cycles after the first acceptance, in order.
5. Backpressure: fill the pipe, then drop `out_ready` for 3 cycles while `in_valid`=1.
   -> `in_ready`=0, `y`/`flags` stable for 3 cycles; after release, every result appears exactly once, in order.
6. Reset mid-operation: 3 operations in flight, assert `reset`=0 for 1 cycle.
   -> `out_valid`=0 on the next cycle and none of the 3 results ever appears; a new operation afterwards completes with normal 4-cycle latency.
